// File: rtl/minority_vec_checker.sv
// Clocked stimulus/response checker for an NIN-input minority gate: sweeps every input vector and counts mismatches.
// Optional first-failure capture is built only when MINCHK_FIRST_FAIL_EN is defined.
module minority_vec_checker #(
    parameter int unsigned NIN    = 3,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERRW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            y,
    output logic [NIN-1:0]  vec,
    output logic            busy,
    output logic            done,
    output logic [ERRW-1:0] errors,
    output logic            pass,
    output logic [NIN-1:0]  first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned     CNTW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
    localparam logic [NIN-1:0]  VEC_LAST    = '1;
    localparam logic [ERRW-1:0] ERR_MAX     = '1;

    // Reject illegal configurations at elaboration time
    if ((NIN % 2) == 0 || NIN == 0 || NIN > 7) begin : g_bad_nin
        $fatal(1, "minority_vec_checker: NIN must be odd and in 1..7");
    end
    if (SETTLE == 0) begin : g_bad_settle
        $fatal(1, "minority_vec_checker: SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NIN-1:0]  vec_q, vec_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            exp_c;
    logic            start_sweep_c;
    logic            mismatch_c;

    // Reference minority value: 1 when fewer than half the inputs are high
    function automatic logic minority(input logic [NIN-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (v[i]) ones++;
        end
        return (2 * ones) < NIN;
    endfunction

    assign exp_c         = minority(vec_q);
    assign start_sweep_c = start && (state_q == S_IDLE || state_q == S_FINISH);
    assign mismatch_c    = (state_q == S_CHECK) && (y != exp_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start_sweep_c) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_CHECK: begin
                // Saturating mismatch count
                if (mismatch_c && err_q != ERR_MAX) begin
                    err_d = err_q + ERRW'(1);
                end
                if (vec_q == VEC_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    vec_d   = vec_q + NIN'(1);
                    cnt_d   = '0;
                    state_d = S_APPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec    = vec_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign errors = err_q;
    assign pass   = done_q && (err_q == '0);

`ifdef MINCHK_FIRST_FAIL_EN
    logic [NIN-1:0] ff_vec_q, ff_vec_d;
    logic           ff_valid_q, ff_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else begin
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
        end
    end

    // Capture only the first mismatch of a sweep; cleared by the next start
    always_comb begin
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        if (start_sweep_c) begin
            ff_vec_d   = '0;
            ff_valid_d = 1'b0;
        end else if (mismatch_c && !ff_valid_q) begin
            ff_vec_d   = vec_q;
            ff_valid_d = 1'b1;
        end
    end

    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`else
    assign first_fail_vec   = '0;
    assign first_fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_minority_vec_checker.sv
// Randomized self-checking bench for minority_vec_checker; the gate under check is a truth table held by the bench.
module tb_minority_vec_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_m, start_a;
    logic [7:0] tbl_m, tbl_a;
    logic       glitch_m, glitch_a;
    logic       y_m, y_a;
    logic       sel;

    logic [2:0] vec_m, vec_a, ffv_m, ffv_a;
    logic       busy_m, busy_a, done_m, done_a, pass_m, pass_a, ffok_m, ffok_a;
    logic [7:0] err_m;
    logic [1:0] err_a;

    logic [2:0] o_vec, o_ffv;
    logic       o_busy, o_done, o_pass, o_ffok;
    logic [7:0] o_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Gate under check: truth table indexed by the applied vector, optionally corrupted between samples
    assign y_m = tbl_m[vec_m] ^ glitch_m;
    assign y_a = tbl_a[vec_a] ^ glitch_a;

    minority_vec_checker #(.NIN(3), .SETTLE(1), .ERRW(8)) u_main (
        .clk(clk), .reset(rst), .start(start_m), .y(y_m), .vec(vec_m), .busy(busy_m),
        .done(done_m), .errors(err_m), .pass(pass_m), .first_fail_vec(ffv_m),
        .first_fail_valid(ffok_m));

    minority_vec_checker #(.NIN(3), .SETTLE(3), .ERRW(2)) u_alt (
        .clk(clk), .reset(rst), .start(start_a), .y(y_a), .vec(vec_a), .busy(busy_a),
        .done(done_a), .errors(err_a), .pass(pass_a), .first_fail_vec(ffv_a),
        .first_fail_valid(ffok_a));

    assign o_vec  = sel ? vec_a  : vec_m;
    assign o_busy = sel ? busy_a : busy_m;
    assign o_done = sel ? done_a : done_m;
    assign o_pass = sel ? pass_a : pass_m;
    assign o_err  = sel ? {6'b0, err_a} : err_m;
    assign o_ffv  = sel ? ffv_a  : ffv_m;
    assign o_ffok = sel ? ffok_a : ffok_m;

    // Reference model: the minority rule straight from its definition
    function automatic bit minority3(input int v);
        logic [2:0] b;
        b = 3'(v);
        return (2 * $countones(b)) < 3;
    endfunction

    function automatic int ref_errors(input logic [7:0] tbl, input int errw);
        int cnt;
        int cap;
        cnt = 0;
        for (int v = 0; v < 8; v++) if (tbl[v] != minority3(v)) cnt++;
        cap = (1 << errw) - 1;
        return (cnt > cap) ? cap : cnt;
    endfunction

    function automatic int ref_first(input logic [7:0] tbl);
        for (int v = 0; v < 8; v++) if (tbl[v] != minority3(v)) return v;
        return -1;
    endfunction

    function automatic logic [7:0] minority_tbl();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = minority3(v);
        return t;
    endfunction

    // Drive one sweep on the selected instance; records done latency and vec/busy/done sequence deviations
    task automatic sweep(input bit alt, input logic [7:0] tbl, input bit glitch, input bit hold,
                         output int lat, output int seq_err);
        int s1;
        int total;
        s1    = alt ? 4 : 2;
        total = 8 * s1;
        sel   = alt;
        if (alt) tbl_a = tbl; else tbl_m = tbl;
        @(negedge clk);
        if (alt) start_a = 1'b1; else start_m = 1'b1;
        @(negedge clk);
        seq_err = 0;
        lat     = -1;
        if (!(o_busy === 1'b1 && o_vec === 3'd0 && o_done === 1'b0)) seq_err++;
        if (alt) start_a = hold; else start_m = hold;
        for (int k = 1; k <= total + 4 && lat < 0; k++) begin
            if (alt) glitch_a = glitch && (k % s1 != 0);
            else     glitch_m = glitch && (k % s1 != 0);
            @(negedge clk);
            if (o_done === 1'b1) lat = k;
            else if (k >= total || o_vec !== 3'(k / s1) || o_busy !== 1'b1) seq_err++;
        end
        glitch_a = 1'b0;
        glitch_m = 1'b0;
    endtask

    // Compare end-of-sweep results against the model
    task automatic check_result(input string name, input bit alt, input logic [7:0] tbl,
                                input int lat, input int seq_err);
        int exp_err;
        int first;
        logic       exp_ok;
        logic [2:0] exp_fv;
        exp_err = ref_errors(tbl, alt ? 2 : 8);
        first   = ref_first(tbl);
        exp_ok  = 1'b0;
        exp_fv  = 3'd0;
`ifdef MINCHK_FIRST_FAIL_EN
        exp_ok  = (first >= 0);
        exp_fv  = (first >= 0) ? 3'(first) : 3'd0;
`endif
        n_tests++;
        if (lat !== (alt ? 32 : 16)) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, alt ? 32 : 16);
        end
        n_tests++;
        if (seq_err !== 0) begin
            n_fail++; $display("FAIL %s sequence: got %0d deviations want 0", name, seq_err);
        end
        n_tests++;
        if (o_err !== 8'(exp_err)) begin
            n_fail++; $display("FAIL %s errors: got %0d want %0d", name, o_err, exp_err);
        end
        n_tests++;
        if (o_pass !== (exp_err == 0) || o_busy !== 1'b0 || o_vec !== 3'd7) begin
            n_fail++; $display("FAIL %s pass/busy/vec: got %b/%b/%0d want %b/0/7", name, o_pass,
                               o_busy, o_vec, exp_err == 0);
        end
        n_tests++;
        if (o_ffok !== exp_ok || o_ffv !== exp_fv) begin
            n_fail++; $display("FAIL %s first_fail: got %b/%0d want %b/%0d", name, o_ffok, o_ffv,
                               exp_ok, exp_fv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 2; a++) begin
            sel = (a == 1);
            #1;
            n_tests++;
            if ({o_vec, o_busy, o_done, o_err, o_pass, o_ffv, o_ffok} !== '0) begin
                n_fail++; $display("FAIL reset_state[%0d]: got vec=%0d busy=%b done=%b err=%0d pass=%b ff=%b/%0d want all 0",
                                   a, o_vec, o_busy, o_done, o_err, o_pass, o_ffok, o_ffv);
            end
        end
    endtask

    task automatic test_patterns();
        int lat, se;
        sweep(0, minority_tbl(), 0, 0, lat, se);  check_result("correct", 0, minority_tbl(), lat, se);
        start_m = 1'b0;
        sweep(0, 8'h00, 0, 0, lat, se);           check_result("stuck0", 0, 8'h00, lat, se);
        start_m = 1'b0;
        sweep(0, ~minority_tbl(), 0, 0, lat, se); check_result("majority", 0, ~minority_tbl(), lat, se);
        start_m = 1'b0;
    endtask

    task automatic test_settle_saturate();
        int lat, se;
        sweep(1, 8'hFF, 0, 0, lat, se);           check_result("alt_stuck1", 1, 8'hFF, lat, se);
        start_a = 1'b0;
        sweep(1, ~minority_tbl(), 0, 0, lat, se); check_result("alt_majority", 1, ~minority_tbl(), lat, se);
        start_a = 1'b0;
        sweep(1, minority_tbl(), 1, 0, lat, se);  check_result("alt_correct_glitch", 1, minority_tbl(), lat, se);
        start_a = 1'b0;
    endtask

    task automatic test_random();
        int lat, se;
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            sweep(i >= 6, t, i[0], 0, lat, se);
            check_result($sformatf("random%0d_tbl%02h", i, t), i >= 6, t, lat, se);
            start_m = 1'b0;
            start_a = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat, se;
        bit hit;
        sel   = 1'b0;
        tbl_m = 8'h00;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (o_vec === 3'd5) hit = 1'b1; else @(negedge clk);
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL reset_mid_reach5: got vec=%0d want 5 within 40 cycles", o_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if ({o_vec, o_busy, o_done, o_err, o_pass, o_ffok} !== '0) begin
                n_fail++; $display("FAIL reset_mid_state[%0d]: got vec=%0d busy=%b done=%b err=%0d want all 0",
                                   c, o_vec, o_busy, o_done, o_err);
            end
            @(negedge clk);
        end
        sweep(0, 8'h00, 0, 0, lat, se);
        check_result("after_reset", 0, 8'h00, lat, se);
        start_m = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, se;
        bit fin;
        sweep(0, ~minority_tbl(), 0, 1, lat, se);
        check_result("hold_start", 0, ~minority_tbl(), lat, se);
        // start still high in FINISH: restart on the very next edge
        tbl_m = minority_tbl();
        @(negedge clk);
        n_tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b1 || o_err !== 8'd0 || o_vec !== 3'd0) begin
            n_fail++; $display("FAIL restart: got done=%b busy=%b err=%0d vec=%0d want 0/1/0/0",
                               o_done, o_busy, o_err, o_vec);
        end
        start_m = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            fin = (o_done === 1'b1);
        end
        n_tests++;
        if (!fin || o_err !== 8'd0 || o_pass !== 1'b1) begin
            n_fail++; $display("FAIL restart_result: got done=%b err=%0d pass=%b want 1/0/1", fin, o_err, o_pass);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start_m  = 1'b0;
        start_a  = 1'b0;
        tbl_m    = 8'h00;
        tbl_a    = 8'h00;
        glitch_m = 1'b0;
        glitch_a = 1'b0;
        sel      = 1'b0;
        test_reset();
        test_patterns();
        test_settle_saturate();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
